// File: rtl/dlfloat_mac_sequencer.sv
// dlfloat_mac_sequencer
//   Byte-serial command sequencer for the DLFloat16 multiply-accumulate
//   datapath. A header byte gives the pair count and an optional
//   accumulator clear. Each operand pair arrives as four bytes, LSB first:
//   a[7:0], a[15:8], b[7:0], b[15:8]. The sequencer issues one accumulate
//   strobe per pair and waits out the MAC pipeline latency. It then returns
//   the captured accumulator MSB-first on a valid/ready byte stream.
//
// Parameters
//   MAC_LAT  cycles from a mac_en cycle until acc_in reflects it (>= 1)
//   LEN_W    width of the pair-count field (up to 2^LEN_W pairs)
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_byte/valid/ready   command and operand byte stream
//   mac_a, mac_b, mac_en  operand pair and one-cycle accumulate strobe
//   mac_clr               one-cycle accumulator clear
//   acc_in                accumulator value returned by the MAC
//   out_byte/valid/ready  result byte stream, MSB first
//   busy                  state is not IDLE
//   done                  one-cycle pulse after the result LSB is taken
//   nan_flag              captured result was 16'hFFFF
module dlfloat_mac_sequencer #(
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned LEN_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic        mac_en,
    output logic        mac_clr,
    input  logic [15:0] acc_in,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        nan_flag
);

    localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_SEND_MSB,
        S_SEND_LSB
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   pair_cnt;
    logic [1:0]         byte_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [15:0]        stage_a;
    logic [15:0]        stage_b;
    logic [15:0]        result;

    logic in_xfer;
    logic out_xfer;

    // Handshake qualifiers; both ready/valid sides are registered.
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pair_cnt  <= '0;
            byte_cnt  <= '0;
            drain_cnt <= '0;
            stage_a   <= '0;
            stage_b   <= '0;
            result    <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            in_ready  <= 1'b0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nan_flag  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            done    <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        pair_cnt <= in_byte[LEN_W-1:0];
                        byte_cnt <= '0;
                        mac_clr  <= in_byte[7];
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (in_xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: stage_a[7:0]  <= in_byte;
                            2'd1: stage_a[15:8] <= in_byte;
                            2'd2: stage_b[7:0]  <= in_byte;
                            default: begin
                                // Last byte completes the pair; bypass it
                                // straight into mac_b.
                                stage_b[15:8] <= in_byte;
                                mac_a         <= stage_a;
                                mac_b         <= {in_byte, stage_b[7:0]};
                                mac_en        <= 1'b1;
                                in_ready      <= 1'b0;
                                state         <= S_ISSUE;
                            end
                        endcase
                    end
                end

                S_ISSUE: begin
                    if (pair_cnt == '0) begin
                        drain_cnt <= DRAIN_W'(MAC_LAT);
                        state     <= S_DRAIN;
                    end else begin
                        pair_cnt <= pair_cnt - LEN_W'(1);
                        in_ready <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_DRAIN: begin
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                    // Capture on the edge where the count reaches zero, so
                    // out_valid follows the last mac_en by MAC_LAT+1 cycles.
                    if (drain_cnt == DRAIN_W'(1)) begin
                        result    <= acc_in;
                        nan_flag  <= (acc_in == 16'hFFFF);
                        out_byte  <= acc_in[15:8];
                        out_valid <= 1'b1;
                        state     <= S_SEND_MSB;
                    end
                end

                S_SEND_MSB: begin
                    if (out_xfer) begin
                        out_byte <= result[7:0];
                        state    <= S_SEND_LSB;
                    end
                end

                S_SEND_LSB: begin
                    if (out_xfer) begin
                        out_valid <= 1'b0;
                        out_byte  <= '0;
                        done      <= 1'b1;
                        nan_flag  <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_sequencer.sv
// tb_dlfloat_mac_sequencer
//   Scoreboard bench: stimulus pushes expected MAC pairs and result bytes
//   into queues, and a negedge monitor pops and compares them as the DUT
//   presents them. A toy MAC (acc += mac_a, MAC_LAT deep) supplies acc_in.
module tb_dlfloat_mac_sequencer;

    localparam int unsigned MAC_LAT = 2;
    localparam int unsigned LEN_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_en;
    logic        mac_clr;
    logic [15:0] acc_in;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        nan_flag;

    dlfloat_mac_sequencer #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .acc_in    (acc_in),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .nan_flag  (nan_flag)
    );

    always #5 clk = ~clk;

    // Toy MAC: accumulate mac_a; one extra delay stage gives MAC_LAT = 2.
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic        force_nan = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            acc_d <= '0;
        end else begin
            if (mac_clr)     acc_q <= '0;
            else if (mac_en) acc_q <= acc_q + mac_a;
            acc_d <= acc_q;
        end
    end
    assign acc_in = force_nan ? 16'hFFFF : acc_d;

    // Scoreboard state
    typedef struct packed { logic [15:0] a; logic [15:0] b; } pair_t;
    typedef struct packed { logic [7:0] b; logic nan; } obyte_t;

    pair_t  mac_q[$];
    obyte_t out_q[$];
    pair_t  exp_p;
    obyte_t exp_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int last_en = 0;
    int clr_cyc = 0;
    bit clr_seen = 1'b0;
    bit gap_chk = 1'b0;
    bit gap_arm = 1'b0;
    bit busy_chk = 1'b0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (mac_clr) begin
                clr_cnt++;
                clr_cyc  = cyc;
                clr_seen = 1'b1;
            end
            if (mac_en) begin
                en_cnt++;
                check("mac_q_nonempty", 32'(mac_q.size() != 0), 32'd1);
                if (mac_q.size() != 0) begin
                    exp_p = mac_q.pop_front();
                    check("mac_a", 32'(mac_a), 32'(exp_p.a));
                    check("mac_b", 32'(mac_b), 32'(exp_p.b));
                end
                if (clr_seen) begin
                    check("clr_lead", 32'(cyc - clr_cyc >= 4), 32'd1);
                    clr_seen = 1'b0;
                end
                if (gap_chk && gap_arm)
                    check("en_gap", 32'(cyc - last_en), 32'd5);
                gap_arm = 1'b1;
                last_en = cyc;
            end
            if (out_valid && !prev_ov)
                check("ov_latency", 32'(cyc - last_en), 32'(MAC_LAT + 1));
            if (out_valid) begin
                check("out_q_nonempty", 32'(out_q.size() != 0), 32'd1);
                if (out_q.size() != 0) begin
                    check("out_byte", 32'(out_byte), 32'(out_q[0].b));
                    check("nan_flag", 32'(nan_flag), 32'(out_q[0].nan));
                    if (out_ready) void'(out_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                busy_chk = 1'b0;
                check("done_after_lsb", 32'(out_q.size()), 32'd0);
                check("nan_clear_at_done", 32'(nan_flag), 32'd0);
            end
            if (busy_chk)
                check("busy", 32'(busy), 32'd1);
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("in_ready_timeout", 32'd1, 32'(in_ready));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit gaps);
        send_byte(a[7:0]);
        if (gaps) begin @(posedge clk); #1; end
        send_byte(a[15:8]);
        if (gaps) begin @(posedge clk); #1; end
        send_byte(b[7:0]);
        if (gaps) begin @(posedge clk); #1; end
        send_byte(b[15:8]);
    endtask

    task automatic expect_pair(input logic [15:0] a, input logic [15:0] b);
        mac_q.push_back({a, b});
    endtask

    task automatic expect_result(input logic [15:0] r, input logic nan);
        out_q.push_back({r[15:8], nan});
        out_q.push_back({r[7:0], nan});
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (done_cnt == d0) check("done_timeout", 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic start_test();
        en_cnt  = 0;
        clr_cnt = 0;
        gap_arm = 1'b0;
    endtask

    task automatic end_test(input string name, input int exp_en, input int exp_clr);
        check({name, "_en_count"}, 32'(en_cnt), 32'(exp_en));
        check({name, "_clr_count"}, 32'(clr_cnt), 32'(exp_clr));
        check({name, "_mac_q_empty"}, 32'(mac_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_mac_ab"}, {mac_a, mac_b}, 32'd0);
        check({name, "_strobes"}, 32'({mac_en, mac_clr, done}), 32'd0);
        check({name, "_out"}, 32'({out_valid, out_byte}), 32'd0);
        check({name, "_flags"}, 32'({busy, nan_flag}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_byte   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Single pair with clear: 1.0 * 1.0 style operands.
        start_test();
        expect_pair(16'h3E00, 16'h3E00);
        expect_result(16'h3E00, 1'b0);
        send_byte(8'h80);
        send_pair(16'h3E00, 16'h3E00, 1'b0);
        wait_done();
        end_test("single", 1, 1);

        // Full-length vector, 16 pairs at full rate; sum of a = 136.
        start_test();
        gap_chk = 1'b1;
        for (int k = 1; k <= 16; k++)
            expect_pair(16'(k), {8'(k), 8'hA5});
        expect_result(16'h0088, 1'b0);
        send_byte(8'h8F);
        busy_chk = 1'b1;
        for (int k = 1; k <= 16; k++)
            send_pair(16'(k), {8'(k), 8'hA5}, 1'b0);
        wait_done();
        gap_chk = 1'b0;
        end_test("full", 16, 1);

        // Backpressure on both streams: 0x0102 + 0x1000 = 0x1102.
        start_test();
        expect_pair(16'h0102, 16'h0304);
        expect_pair(16'h1000, 16'hABCD);
        expect_result(16'h1102, 1'b0);
        send_byte(8'h81);
        send_pair(16'h0102, 16'h0304, 1'b1);
        send_pair(16'h1000, 16'hABCD, 1'b1);
        out_ready = 1'b0;
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
        end
        repeat (4) @(posedge clk);
        #1;
        check("msb_held", 32'({out_valid, out_byte}), 32'h111);
        check("no_done_in_stall", 32'(done), 32'd0);
        out_ready = 1'b1;
        wait_done();
        end_test("bp", 2, 1);

        // Reset in the middle of a pair, then a fresh single pair.
        start_test();
        send_byte(8'h80);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        check("mid_reset_no_en", 32'(en_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_test();
        expect_pair(16'h0005, 16'h0006);
        expect_result(16'h0005, 1'b0);
        send_byte(8'h00);
        send_pair(16'h0005, 16'h0006, 1'b0);
        wait_done();
        end_test("after_reset", 1, 0);

        // Two pairs without clear, MAC returns all-ones.
        start_test();
        force_nan = 1'b1;
        expect_pair(16'h0001, 16'h0002);
        expect_pair(16'h0003, 16'h0004);
        expect_result(16'hFFFF, 1'b1);
        send_byte(8'h01);
        send_pair(16'h0001, 16'h0002, 1'b0);
        send_pair(16'h0003, 16'h0004, 1'b0);
        wait_done();
        force_nan = 1'b0;
        end_test("nan", 2, 0);
        check("final_out_q_empty", 32'(out_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
